// File: rtl/led_s2p_pkg.sv
// Shared constants for the LED shift-chain protocol (serializer and receiver).
// Also holds the receiver state type and the helper that derives the state from the bit count.
package led_s2p_pkg;

  localparam int LED_DATA_BITS       = 16;
  localparam int LED_DATA_COUNT_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVER
  } state_e;

  // The receiver state is not stored separately; it is fully implied by the bit count.
  function automatic state_e cnt_to_state(input int cnt, input int data_bits);
    if (cnt == 0)              return ST_IDLE;
    else if (cnt <= data_bits) return ST_SHIFT;
    else                       return ST_OVER;
  endfunction

endpackage

// File: rtl/led_s2p_sync_rise.sv
// Two-flop synchronizer for one asynchronous input.
// An optional third flop provides a single-cycle rising-edge pulse.
module sync_rise #(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic sync,
  output logic rise
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign sync = r_sync;

  generate
    if (EDGE_DETECT) begin : g_edge
      logic r_prev;
      always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= r_sync;
      end
      assign rise = r_sync & ~r_prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/led_s2p.sv
// LED shift-chain receiver: rebuilds the serial word on the system clock and latches it on s_pen.
// Clear beats latch, and latch beats shift, when several of them land in the same cycle.
module led_s2p
  import led_s2p_pkg::*;
#(
  parameter int DATA_BITS       = LED_DATA_BITS,
  parameter int DATA_COUNT_BITS = LED_DATA_COUNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_data,
  input  logic                 s_clrn,
  input  logic                 s_pen,
  output logic [DATA_BITS-1:0] P_Data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int                CNT_W    = DATA_COUNT_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);

  logic w_sclk_rise;
  logic w_pen_rise;
  logic w_data_sync;
  logic w_clrn_sync;
  logic w_sclk_sync;
  logic w_pen_sync;
  logic w_data_rise;
  logic w_clrn_rise;
  logic w_unused_sync;

  sync_rise #(.EDGE_DETECT(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_async(s_clk), .sync(w_sclk_sync), .rise(w_sclk_rise)
  );
  sync_rise #(.EDGE_DETECT(1'b1)) u_sync_pen (
    .clk(clk), .rst(rst), .i_async(s_pen), .sync(w_pen_sync), .rise(w_pen_rise)
  );
  sync_rise #(.EDGE_DETECT(1'b0)) u_sync_data (
    .clk(clk), .rst(rst), .i_async(s_data), .sync(w_data_sync), .rise(w_data_rise)
  );
  sync_rise #(.EDGE_DETECT(1'b0)) u_sync_clrn (
    .clk(clk), .rst(rst), .i_async(s_clrn), .sync(w_clrn_sync), .rise(w_clrn_rise)
  );

  assign w_unused_sync = w_sclk_sync | w_pen_sync | w_data_rise | w_clrn_rise;

  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
  logic [DATA_BITS-1:0] r_pdata, w_pdata_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr,  w_ferr_nxt;
  state_e               w_state;

  assign w_state = cnt_to_state(32'(r_cnt), DATA_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_pdata <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pdata <= w_pdata_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_pdata_nxt = r_pdata;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    if (!w_clrn_sync) begin
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (w_pen_rise) begin
      // A coincident s_clk rise is dropped here; shreg is kept for inspection.
      w_cnt_nxt = '0;
      if (w_state == ST_SHIFT && r_cnt == CNT_FULL) begin
        w_pdata_nxt = r_shreg;
        w_valid_nxt = 1'b1;
      end else begin
        w_ferr_nxt = 1'b1;
      end
    end else if (w_sclk_rise) begin
      w_shreg_nxt = {r_shreg[DATA_BITS-2:0], w_data_sync};
      if (w_state != ST_OVER) w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign P_Data    = r_pdata;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (w_state != ST_IDLE);

endmodule

// File: tb/tb_led_s2p.sv
// Self-checking bench for led_s2p: drives the serial pins slowly and compares against a bit-queue model.
// The model only tracks received bits and the last good word.
module tb_led_s2p;

  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_clk;
  logic          s_data;
  logic          s_clrn;
  logic          s_pen;
  logic [DB-1:0] P_Data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  bit            m_bits[$];
  logic [DB-1:0] m_pdata;

  always #5 clk = ~clk;

  led_s2p #(.DATA_BITS(DB), .DATA_COUNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_data(s_data), .s_clrn(s_clrn),
    .s_pen(s_pen), .P_Data(P_Data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The word the chain holds is simply the last DB bits received, oldest first.
  function automatic logic [DB-1:0] model_word();
    logic [DB-1:0] w = '0;
    foreach (m_bits[i]) w = {w[DB-2:0], m_bits[i]};
    return w;
  endfunction

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      s_clk  = 1'b0;
      s_data = v[i];
      wait_clks(4);
      s_clk = 1'b1;
      m_bits.push_back(v[i]);
      wait_clks(4);
    end
    s_clk = 1'b0;
    wait_clks(4);
  endtask

  task automatic chain_clear();
    s_clrn = 1'b0;
    wait_clks(4);
    s_clrn = 1'b1;
    m_bits.delete();
    wait_clks(4);
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      failures++;
      $display("FAIL %s busy: got %b expected %b", name, busy, exp);
    end
  endtask

  task automatic do_latch(input string name, input bit coincident);
    int nv, nf, nboth, exp_nv, exp_nf;
    bit good;
    good = (m_bits.size() == DB);
    if (good) m_pdata = model_word();
    m_bits.delete();
    exp_nv = good ? 1 : 0;
    exp_nf = good ? 0 : 1;
    nv = 0; nf = 0; nboth = 0;
    s_pen = 1'b1;
    if (coincident) s_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
      if (frame_err === 1'b1) nf++;
      if (valid === 1'b1 && frame_err === 1'b1) nboth++;
    end
    checks++;
    if (nv != exp_nv) begin
      failures++;
      $display("FAIL %s valid_cycles: got %0d expected %0d", name, nv, exp_nv);
    end
    checks++;
    if (nf != exp_nf) begin
      failures++;
      $display("FAIL %s frame_err_cycles: got %0d expected %0d", name, nf, exp_nf);
    end
    checks++;
    if (nboth != 0) begin
      failures++;
      $display("FAIL %s valid_and_err_together: got %0d cycles expected 0", name, nboth);
    end
    checks++;
    if (P_Data !== m_pdata) begin
      failures++;
      $display("FAIL %s P_Data: got %h expected %h", name, P_Data, m_pdata);
    end
    check_busy(name, 1'b0);
    s_pen = 1'b0;
    s_clk = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_reset();
    checks++;
    if (P_Data !== '0 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got P_Data=%h valid=%b err=%b busy=%b expected 0000 0 0 0",
               P_Data, valid, frame_err, busy);
    end
  endtask

  task automatic test_good_frame();
    chain_clear();
    send_bits(32'h0000_A5C3, 16);
    check_busy("good_frame", 1'b1);
    do_latch("good_frame", 1'b0);
  endtask

  task automatic test_short_frame();
    send_bits(32'h0000_7FFF, 15);
    do_latch("short_frame", 1'b0);
  endtask

  task automatic test_overrun();
    send_bits({15'd0, 1'b1, 16'h1234}, 17);
    check_busy("overrun", 1'b1);
    do_latch("overrun", 1'b0);
  endtask

  task automatic test_clear();
    send_bits(32'($urandom_range(0, 255)), 8);
    check_busy("clear_pre", 1'b1);
    chain_clear();
    check_busy("clear_post", 1'b0);
    send_bits(32'h0000_1234, 16);
    do_latch("clear_then_frame", 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int nerr;
    send_bits(32'h0000_03A5, 10);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    m_bits.delete();
    m_pdata = '0;
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1 || valid === 1'b1) nerr++;
    end
    checks++;
    if (P_Data !== '0) begin
      failures++;
      $display("FAIL reset_mid P_Data: got %h expected 0000", P_Data);
    end
    checks++;
    if (nerr != 0) begin
      failures++;
      $display("FAIL reset_mid pulses: got %0d expected 0", nerr);
    end
    check_busy("reset_mid", 1'b0);
    send_bits(32'h0000_FFFF, 16);
    do_latch("after_reset", 1'b0);
  endtask

  task automatic test_coincident();
    send_bits(32'h0000_00FF, 16);
    do_latch("coincident", 1'b1);
    send_bits(32'h0000_5A3C, 16);
    do_latch("post_coincident", 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int n;
      logic [31:0] w;
      n = 15 + int'($urandom_range(0, 2));
      w = $urandom;
      send_bits(w, n);
      do_latch($sformatf("random%0d_n%0d", k, n), 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_clk   = 1'b0;
    s_data  = 1'b0;
    s_clrn  = 1'b1;
    s_pen   = 1'b0;
    m_pdata = '0;
    wait_clks(5);
    test_reset();
    rst = 1'b0;
    wait_clks(4);
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_clear();
    test_reset_mid_frame();
    test_coincident();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
